// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state enum, the row/column key map and the row priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_e;

  // Index is {row, col}. Row 0 occupies the low nibbles.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    casez (r)
      4'b???0: return 2'd0;
      4'b??01: return 2'd1;
      4'b?011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones so that an idle, pulled-up keypad reads as "no key".
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, row debounce on press and release,
// and a two-deep history of accepted keys for the dual-digit display mux.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  // The cycle that enters DEBOUNCE/RELEASE already counts as the first stable cycle.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);

  kp_state_e     state, state_nx;
  logic [SW-1:0] scan_cnt, scan_cnt_nx;
  logic [DW-1:0] db_cnt, db_cnt_nx;
  logic [1:0]    col_idx, col_nx, row_idx, row_nx;
  logic [3:0]    dnew_nx, dold_nx;
  logic          kv_nx;
  logic [3:0]    rows_s;
  logic          tick, row_low;
  logic [DW-1:0] db_inc;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign cols    = ~(4'b0001 << col_idx);
  assign tick    = (scan_cnt == SCAN_LAST);
  assign row_low = ~rows_s[row_idx];
  assign db_inc  = (db_cnt == '1) ? db_cnt : db_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      col_idx   <= '0;
      row_idx   <= '0;
      digit_new <= '0;
      digit_old <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      scan_cnt  <= scan_cnt_nx;
      db_cnt    <= db_cnt_nx;
      col_idx   <= col_nx;
      row_idx   <= row_nx;
      digit_new <= dnew_nx;
      digit_old <= dold_nx;
      key_valid <= kv_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    scan_cnt_nx = scan_cnt;
    db_cnt_nx   = db_cnt;
    col_nx      = col_idx;
    row_nx      = row_idx;
    dnew_nx     = digit_new;
    dold_nx     = digit_old;
    kv_nx       = 1'b0;
    case (state)
      SCAN: begin
        scan_cnt_nx = tick ? '0 : scan_cnt + 1'b1;
        if (tick) begin
          if (rows_s != 4'hF) begin
            row_nx    = lowest_low_row(rows_s);
            db_cnt_nx = '0;
            state_nx  = DEBOUNCE;
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          state_nx = SCAN;
        end else if (db_cnt == DB_LAST) begin
          dold_nx  = digit_new;
          dnew_nx  = KEY_MAP[{row_idx, col_idx}];
          kv_nx    = 1'b1;
          state_nx = HELD;
        end else begin
          db_cnt_nx = db_inc;
        end
      end
      HELD: begin
        if (!row_low) begin
          db_cnt_nx = '0;
          state_nx  = RELEASE;
        end
      end
      RELEASE: begin
        if (row_low) begin
          db_cnt_nx = '0;
          state_nx  = HELD;
        end else if (db_cnt == DB_LAST) begin
          scan_cnt_nx = '0;
          col_nx      = col_idx + 2'd1;
          state_nx    = SCAN;
        end else begin
          db_cnt_nx = db_inc;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad matrix model drives rows
// from cols, and a key-history model predicts the accepted digits and pulse count.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_new, digit_old;
  logic       key_valid;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pressed[r][c]: key at row r / column c is physically closed.
  logic [3:0][3:0] pressed;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  int         kv_cnt;
  logic [3:0] cap_new, cap_old;
  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt  <= kv_cnt + 1;
      cap_new <= digit_new;
      cap_old <= digit_old;
    end
  end

  int         n_tests, n_fail;
  int         exp_pulses;
  logic [3:0] exp_new, exp_old;

  function automatic logic [3:0] key_of(input int r, input int c);
    case (r * 4 + c)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
     12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
    endcase
  endfunction

  task automatic model_accept(input int r, input int c);
    exp_old    = exp_new;
    exp_new    = key_of(r, c);
    exp_pulses = exp_pulses + 1;
  endtask

  task automatic wait_cols(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (cols === want) ok = 1'b1;
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    @(negedge clk);
    pressed[r][c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[r][c] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pressed = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL reset_cols got %b want 1110", cols); end
    n_tests++; if (digit_new !== 4'h0) begin n_fail++; $display("FAIL reset_dnew got %h want 0", digit_new); end
    n_tests++; if (digit_old !== 4'h0) begin n_fail++; $display("FAIL reset_dold got %h want 0", digit_old); end
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv got %b want 0", key_valid); end
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] want;
      @(posedge clk); #1;
      want = ~(4'b0001 << ((k / 4) % 4));
      n_tests++; if (cols !== want) begin n_fail++; $display("FAIL scan_step k=%0d got %b want %b", k, cols, want); end
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    pressed[1][2] = 1'b1;
    repeat (50) @(negedge clk);
    model_accept(1, 2);
    n_tests++; if (cols !== 4'b1011) begin n_fail++; $display("FAIL held_cols got %b want 1011", cols); end
    pressed[1][2] = 1'b0;
    repeat (5) @(posedge clk); #1;
    n_tests++; if (cols !== 4'b1011) begin n_fail++; $display("FAIL release_frozen got %b want 1011", cols); end
    repeat (5) @(posedge clk); #1;
    n_tests++; if (cols !== 4'b0111) begin n_fail++; $display("FAIL release_advance got %b want 0111", cols); end
    repeat (20) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL press6_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (cap_new !== exp_new || cap_old !== exp_old) begin n_fail++; $display("FAIL press6_at_pulse got %h/%h want %h/%h", cap_new, cap_old, exp_new, exp_old); end
    n_tests++; if (digit_new !== exp_new || digit_old !== exp_old) begin n_fail++; $display("FAIL press6_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); end
  endtask

  task automatic test_bounce();
    bit ok;
    wait_cols(4'b1011, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bounce_wait got timeout want cols 1011"); end
    press(1, 2, 3);
    wait_cols(4'b0111, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bounce_resume got timeout want cols 0111"); end
    repeat (20) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL bounce_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (digit_new !== exp_new || digit_old !== exp_old) begin n_fail++; $display("FAIL bounce_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); end
  endtask

  task automatic test_hold_other();
    @(negedge clk);
    pressed[1][2] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[0][0] = 1'b1;
    repeat (140) @(negedge clk);
    pressed = '0;
    model_accept(1, 2);
    repeat (30) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL hold_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (digit_new !== exp_new || digit_old !== exp_old) begin n_fail++; $display("FAIL hold_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); end
    press(0, 3, 50);
    model_accept(0, 3);
    repeat (30) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL keyA_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (digit_new !== 4'hA || digit_old !== 4'h6) begin n_fail++; $display("FAIL keyA_digits got %h/%h want a/6", digit_new, digit_old); end
  endtask

  task automatic test_same_col();
    @(negedge clk);
    pressed[1][0] = 1'b1; pressed[2][0] = 1'b1;
    repeat (50) @(negedge clk);
    pressed = '0;
    model_accept(1, 0);
    repeat (30) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL samecol_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (digit_new !== 4'h4 || digit_old !== exp_old) begin n_fail++; $display("FAIL samecol_digits got %h/%h want 4/%h", digit_new, digit_old, exp_old); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_cols(4'b1101, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_wait1 got timeout want cols 1101"); end
    @(negedge clk);
    pressed[2][2] = 1'b1;
    wait_cols(4'b1011, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_wait2 got timeout want cols 1011"); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_new = 4'h0; exp_old = 4'h0;
    n_tests++; if (digit_new !== 4'h0 || digit_old !== 4'h0) begin n_fail++; $display("FAIL rmid_digits got %h/%h want 0/0", digit_new, digit_old); end
    n_tests++; if (cols !== 4'b1110) begin n_fail++; $display("FAIL rmid_cols got %b want 1110", cols); end
    pressed = '0;
    repeat (4) @(negedge clk);
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_kv got %b want 0", key_valid); end
    reset = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL rmid_pending got %0d want %0d", kv_cnt, exp_pulses); end
    press(2, 2, 50);
    model_accept(2, 2);
    repeat (30) @(negedge clk);
    n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL key9_pulses got %0d want %0d", kv_cnt, exp_pulses); end
    n_tests++; if (digit_new !== 4'h9 || digit_old !== 4'h0) begin n_fail++; $display("FAIL key9_digits got %h/%h want 9/0", digit_new, digit_old); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int r, c, kind;
      r    = int'($urandom_range(0, 3));
      c    = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        press(r, c, int'($urandom_range(1, 7)));
      end else begin
        press(r, c, int'($urandom_range(40, 80)));
        model_accept(r, c);
      end
      repeat (int'($urandom_range(25, 40))) @(negedge clk);
      n_tests++; if (kv_cnt !== exp_pulses) begin n_fail++; $display("FAIL rand%0d_pulses got %0d want %0d", it, kv_cnt, exp_pulses); end
      n_tests++; if (digit_new !== exp_new || digit_old !== exp_old) begin n_fail++; $display("FAIL rand%0d_digits got %h/%h want %h/%h", it, digit_new, digit_old, exp_new, exp_old); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_pulses = 0;
    exp_new = 4'h0; exp_old = 4'h0;
    kv_cnt = 0; cap_new = 4'h0; cap_old = 4'h0;
    pressed = '0; reset = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_other();
    test_same_col();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
